// File: rtl/sha256_round_engine_pkg.sv
// sha256_round_engine_pkg
//   Shared definitions for the SHA-256 compression round engine:
//   - state_t     : FSM state encodings (IDLE / ROUND / FINAL / DONE)
//   - SHA256_K    : the 64 round constants K[0..63]
//   - SHA256_IV   : the standard initial hash value H(0), H0 in [255:224]
//   - rotr32      : 32-bit rotate-right helper used by the sigma function modules
package sha256_round_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  // Rotate right by a constant amount in 1..31.
  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// sha256_k_rom
//   Combinational ROM of the SHA-256 round constants.
//   Ports:
//     idx : input  [5:0]  round index t
//     k   : output [31:0] K[t]
module sha256_k_rom
  import sha256_round_engine_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);
  assign k = SHA256_K[idx];
endmodule

// File: rtl/sha256_round_engine_funcs.sv
// SHA-256 combinational round helpers (compression variants).
//   sha256_big_sigma0 : x -> y = ROTR2(x) ^ ROTR13(x) ^ ROTR22(x)
//   sha256_big_sigma1 : x -> y = ROTR6(x) ^ ROTR11(x) ^ ROTR25(x)
//   sha256_ch         : (x,y,z) -> out = (x & y) ^ (~x & z)
//   sha256_maj        : (x,y,z) -> out = (x & y) ^ (x & z) ^ (y & z)
module sha256_big_sigma0
  import sha256_round_engine_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
endmodule

module sha256_big_sigma1
  import sha256_round_engine_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
endmodule

module sha256_ch (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  output logic [31:0] out
);
  assign out = (x & y) ^ (~x & z);
endmodule

module sha256_maj (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  output logic [31:0] out
);
  assign out = (x & y) ^ (x & z) ^ (y & z);
endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine
//   Iterative SHA-256 compression engine. Latches a chaining value on start,
//   performs one round per accepted message-schedule word (valid/ready), then
//   folds the working variables back into the chaining value and pulses done.
//
//   Ports:
//     clk       : input        rising-edge clock
//     rst       : input        synchronous active-high reset
//     start     : input        block request, honoured only in IDLE
//     hash_in   : input  [255] chaining value, H0 in [255:224]
//     w_valid   : input        W_t present on w_data
//     w_data    : input  [31]  message schedule word W_t
//     w_ready   : output       engine takes W_t this cycle (ROUND state)
//     busy      : output       block in progress (ROUND and FINAL)
//     done      : output       one-cycle pulse after hash_out is updated
//     hash_out  : output [255] updated chaining value, same packing as hash_in
//
//   Optional build macro SHA256_ROUND_DBG_EN adds:
//     dbg_round : output [5:0]  current round index t
//     dbg_a     : output [31:0] working register a
module sha256_round_engine
  import sha256_round_engine_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*WORD_W-1:0]   hash_in,
  input  logic                  w_valid,
  input  logic [WORD_W-1:0]     w_data,
  output logic                  w_ready,
  output logic                  busy,
  output logic                  done,
  output logic [8*WORD_W-1:0]   hash_out
`ifdef SHA256_ROUND_DBG_EN
  ,
  output logic [5:0]            dbg_round,
  output logic [WORD_W-1:0]     dbg_a
`endif
);

  state_t state_q, state_d;

  logic [5:0]          t_q;
  // work_q[0..7] hold a..h; chain_q[0..7] hold H0..H7.
  logic [WORD_W-1:0]   work_q  [8];
  logic [WORD_W-1:0]   chain_q [8];
  logic [8*WORD_W-1:0] hash_q;

  logic [WORD_W-1:0]   k_t;
  logic [WORD_W-1:0]   sig0_a;
  logic [WORD_W-1:0]   sig1_e;
  logic [WORD_W-1:0]   ch_efg;
  logic [WORD_W-1:0]   maj_abc;
  logic [WORD_W-1:0]   t1;
  logic [WORD_W-1:0]   t2;
  logic [WORD_W-1:0]   final_sum [8];
  logic                round_fire;
  logic                last_round;

  sha256_k_rom u_k_rom (
    .idx (t_q),
    .k   (k_t)
  );

  sha256_big_sigma0 u_sig0 (
    .x (work_q[0]),
    .y (sig0_a)
  );

  sha256_big_sigma1 u_sig1 (
    .x (work_q[4]),
    .y (sig1_e)
  );

  sha256_ch u_ch (
    .x   (work_q[4]),
    .y   (work_q[5]),
    .z   (work_q[6]),
    .out (ch_efg)
  );

  sha256_maj u_maj (
    .x   (work_q[0]),
    .y   (work_q[1]),
    .z   (work_q[2]),
    .out (maj_abc)
  );

  // A round only advances when a word is actually handed over.
  assign round_fire = (state_q == ST_ROUND) && w_valid;
  assign last_round = (t_q == 6'(ROUNDS - 1));

  assign t1 = work_q[7] + sig1_e + ch_efg + k_t + w_data;
  assign t2 = sig0_a + maj_abc;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      final_sum[i] = chain_q[i] + work_q[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start is only honoured in IDLE, so a start coinciding
  // with done (DONE state) is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ROUND;
      ST_ROUND: if (round_fire && last_round) state_d = ST_FINAL;
      ST_FINAL: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    w_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_ROUND: begin
        w_ready = 1'b1;
        busy    = 1'b1;
      end
      ST_FINAL: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch on start, shift the working variables on each fired round,
  // fold into the chaining value in FINAL. hash_q only changes in FINAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q    <= '0;
      hash_q <= '0;
      for (int i = 0; i < 8; i++) begin
        work_q[i]  <= '0;
        chain_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            t_q <= '0;
            for (int i = 0; i < 8; i++) begin
              chain_q[i] <= hash_in[8*WORD_W-1-WORD_W*i -: WORD_W];
              work_q[i]  <= hash_in[8*WORD_W-1-WORD_W*i -: WORD_W];
            end
          end
        end
        ST_ROUND: begin
          if (round_fire) begin
            work_q[7] <= work_q[6];
            work_q[6] <= work_q[5];
            work_q[5] <= work_q[4];
            work_q[4] <= work_q[3] + t1;
            work_q[3] <= work_q[2];
            work_q[2] <= work_q[1];
            work_q[1] <= work_q[0];
            work_q[0] <= t1 + t2;
            t_q       <= t_q + 6'd1;
          end
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            chain_q[i] <= final_sum[i];
            hash_q[8*WORD_W-1-WORD_W*i -: WORD_W] <= final_sum[i];
          end
        end
        default: ;
      endcase
    end
  end

  assign hash_out = hash_q;

`ifdef SHA256_ROUND_DBG_EN
  assign dbg_round = t_q;
  assign dbg_a     = work_q[0];
`endif

endmodule

// File: tb/tb_sha256_round_engine.sv
// tb_sha256_round_engine
//   Directed bench for sha256_round_engine: known single- and two-block
//   digests, random input stalls, ignored start pulses, and mid-run reset.
module tb_sha256_round_engine;
  import sha256_round_engine_pkg::*;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_BLOCK_DIGEST =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] hash_in;
  logic         w_valid;
  logic [31:0]  w_data;
  logic         w_ready;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;
`ifdef SHA256_ROUND_DBG_EN
  logic [5:0]   dbg_round;
  logic [31:0]  dbg_a;
`endif

  logic [31:0]  msg_blk [16];
  logic [31:0]  sched   [64];

  int vec_count        = 0;
  int miscompare_count = 0;

  always #5 clk = ~clk;

  sha256_round_engine #(
    .ROUNDS (64),
    .WORD_W (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hash_in  (hash_in),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_ready  (w_ready),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
`ifdef SHA256_ROUND_DBG_EN
    ,
    .dbg_round (dbg_round),
    .dbg_a     (dbg_a)
`endif
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Message scheduler model: expands msg_blk into sched[0..63].
  task automatic buildSchedule();
    for (int t = 0; t < 16; t++) sched[t] = msg_blk[t];
    for (int t = 16; t < 64; t++)
      sched[t] = small_s1(sched[t-2]) + sched[t-7] + small_s0(sched[t-15]) + sched[t-16];
  endtask

  // Runs one block starting at a negedge in an IDLE cycle; returns at the
  // negedge of the cycle where done is high (or on timeout).
  task automatic applyStimulus(input logic [255:0] iv, input int stall_pct,
                               input int restart_at, input bit check_prior,
                               input logic [255:0] prior, input bit check_digest,
                               input logic [255:0] expected, input string tag);
    int cyc;
    int idx;
    int stalls;
    bit busy_bad;
    bit prior_bad;
    busy_bad  = 1'b0;
    prior_bad = 1'b0;
    buildSchedule();
    hash_in = iv;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cyc    = 1;
    idx    = 0;
    stalls = 0;
    while (cyc < 400) begin
      if (done) break;
      if (!busy) busy_bad = 1'b1;
      if (check_prior && (hash_out !== prior)) prior_bad = 1'b1;
      start   = 1'b0;
      hash_in = iv;
      if (idx == restart_at) begin
        start   = 1'b1;
        hash_in = ~iv;
      end
      if (idx < 64) begin
        if ($urandom_range(99) < stall_pct) begin
          w_valid = 1'b0;
          w_data  = 32'hdeadbeef;
          stalls++;
        end else begin
          w_valid = 1'b1;
          w_data  = sched[idx];
          if (w_ready) idx++;
        end
      end else begin
        // Junk offered after the last round must not be consumed.
        w_valid = 1'b1;
        w_data  = 32'hbad0bad0;
      end
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    hash_in = iv;
    checkOutput({tag, "_done_cycle"}, 256'(cyc), 256'(66 + stalls));
    if (check_digest) checkOutput({tag, "_digest"}, hash_out, expected);
    checkOutput({tag, "_busy_held"}, 256'(busy_bad), 256'(0));
    checkOutput({tag, "_busy_at_done"}, 256'(busy), 256'(0));
    if (check_prior) checkOutput({tag, "_hash_held"}, 256'(prior_bad), 256'(0));
  endtask

  task automatic loadAbc();
    for (int i = 0; i < 16; i++) msg_blk[i] = 32'h0;
    msg_blk[0]  = 32'h61626380;
    msg_blk[15] = 32'h00000018;
  endtask

  initial begin
    bit saw_done;
    rst     = 1'b1;
    start   = 1'b0;
    w_valid = 1'b0;
    w_data  = 32'h0;
    hash_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_w_ready", 256'(w_ready), 256'(0));
    checkOutput("reset_busy", 256'(busy), 256'(0));
    checkOutput("reset_done", 256'(done), 256'(0));
    checkOutput("reset_hash", hash_out, 256'(0));
    rst = 1'b0;
    w_valid = 1'b1;
    @(negedge clk);
    checkOutput("idle_w_ready", 256'(w_ready), 256'(0));

    // "abc", no stalls.
    loadAbc();
    applyStimulus(SHA256_IV, 0, -1, 1'b0, '0, 1'b1, ABC_DIGEST, "abc");
    @(negedge clk);
    checkOutput("abc_done_pulse", 256'(done), 256'(0));
    checkOutput("abc_hash_holds", hash_out, ABC_DIGEST);

    // Empty message, started in the IDLE cycle right after done.
    for (int i = 0; i < 16; i++) msg_blk[i] = 32'h0;
    msg_blk[0] = 32'h80000000;
    applyStimulus(SHA256_IV, 0, -1, 1'b1, ABC_DIGEST, 1'b1, EMPTY_DIGEST, "empty");
    @(negedge clk);

    // "abc" with ~30% stall cycles.
    loadAbc();
    applyStimulus(SHA256_IV, 30, -1, 1'b1, EMPTY_DIGEST, 1'b1, ABC_DIGEST, "abc_stall");
    @(negedge clk);

    // "abc" with a stray start pulse at round 10.
    applyStimulus(SHA256_IV, 0, 10, 1'b1, ABC_DIGEST, 1'b1, ABC_DIGEST, "abc_restart");
    @(negedge clk);

    // Reset after 40 rounds of an "abc" run.
    buildSchedule();
    hash_in = SHA256_IV;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      w_valid = 1'b1;
      w_data  = sched[i];
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_w_ready", 256'(w_ready), 256'(0));
    checkOutput("midrst_busy", 256'(busy), 256'(0));
    checkOutput("midrst_done", 256'(done), 256'(0));
    checkOutput("midrst_hash", hash_out, 256'(0));
    saw_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      w_valid = 1'b1;
      w_data  = sched[i % 64];
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checkOutput("midrst_stays_idle", 256'(saw_done), 256'(0));
    applyStimulus(SHA256_IV, 0, -1, 1'b1, '0, 1'b1, ABC_DIGEST, "abc_after_rst");

    // Two-block message; a start during DONE is offered and must be ignored.
    @(negedge clk);
    msg_blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    applyStimulus(SHA256_IV, 0, -1, 1'b1, ABC_DIGEST, 1'b0, '0, "blk1");
    start   = 1'b1;
    hash_in = ~SHA256_IV;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_in_done_busy", 256'(busy), 256'(0));
    checkOutput("start_in_done_ready", 256'(w_ready), 256'(0));
    for (int i = 0; i < 16; i++) msg_blk[i] = 32'h0;
    msg_blk[15] = 32'h000001c0;
    applyStimulus(hash_out, 0, -1, 1'b0, '0, 1'b1, TWO_BLOCK_DIGEST, "blk2");
    w_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/sha256_round_engine.md
Name: sha256_round_engine

Overview:
- Iterative SHA-256 compression round engine; sits directly downstream of the Σ0/Σ1/Ch/Maj combinational helpers and instantiates them.
- Consumes one 32-bit message schedule word W_t per round from the message scheduler over a valid/ready handshake.
- Runs 64 rounds, one per accepted word, then adds the working variables into the chaining value and presents the 256-bit result.

Parameters:
- ROUNDS, 64, number of compression rounds. Only 64 is a supported value; it is a parameter so benches can reference the constant.
- WORD_W, 32, SHA-256 word width. Fixed at 32.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; accepted only in IDLE.
- hash_in  input  256  chaining value H0..H7; H0 occupies [255:224].
- w_valid  input  1  W_t is present on w_data.
- w_data  input  32  message schedule word W_t.
- w_ready  output  1  engine accepts W_t this cycle.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when hash_out is updated.
- hash_out  output  256  updated chaining value, same packing as hash_in.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; round counter goes to 0.
  - w_ready=0, busy=0, done=0, hash_out=0.
  - Working registers a..h and the H registers are cleared.
  - Reset mid-run aborts the block with no done pulse.
- IDLE:
  - w_ready=0.
  - On start=1: latch hash_in into H0..H7 and into a..h, set t=0, go to ROUND.
- ROUND:
  - w_ready=1 and busy=1.
  - A round fires only on the cycle where w_valid & w_ready. Then:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + w_data
    - T2 = Σ0(a) + Maj(a,b,c)
    - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
    - All additions are mod 2^32 (carry discarded); t increments.
  - w_valid=0 stalls the round: no register changes, unbounded stall allowed.
  - When the round with t=63 fires, go to FINAL.
- FINAL (1 cycle):
  - w_ready=0.
  - Hi ← Hi + working var (mod 2^32, per word).
  - hash_out is registered from the sums.
  - Go to DONE.
- DONE (1 cycle):
  - done=1, busy=0; go to IDLE.
  - hash_out holds until the next FINAL or reset.
- Latency: with w_valid held high, start accepted at cycle 0 gives done=1 at cycle 66 (64 rounds + FINAL + DONE). Each stall cycle adds 1.
- Boundary conditions:
  - start while not IDLE is ignored; hash_in is not resampled.
  - w_valid outside ROUND is ignored; no word is consumed.
  - start in the same cycle as done (state DONE) is ignored. start is accepted from the following IDLE cycle.
  - The round counter never wraps inside a block; t=63 always exits to FINAL.
- K[0..63] are the standard FIPS 180-4 constants, held as a combinational ROM indexed by t.

Optional Feature:
- Macro: SHA256_ROUND_DBG_EN.
- Defined: adds output ports dbg_round [5:0] (current t) and dbg_a [31:0] (register a). Both reset to 0 and are valid every cycle.
- Undefined: these ports do not exist and there is no functional difference.

Decomposition:
- Shared package/include:
  - the K[0..63] constant table;
  - the FSM state encodings IDLE/ROUND/FINAL/DONE;
  - the SHA-256 initial hash constants (0x6a09e667 … 0x5be0cd19) for benches.
- Σ0/Σ1 (compression variants), Ch and Maj are the existing combinational function modules, instantiated rather than re-coded.
- One natural sub-module: sha256_k_rom (6-bit index → 32-bit K[t]).

Test Plan:
- Message "abc" as one block, IV = standard H(0). Bench feeds W_0=0x61626380, W_1..W_14=0, W_15=0x00000018, then W_16..W_63 computed by the scheduler model, with no stalls.
  → done at cycle 66; hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: W_0=0x80000000, W_1..W_15=0, rest scheduled.
  → hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Same "abc" run with w_valid deasserted on a random 30% of cycles.
  → identical hash_out; done cycle = 66 + number of stall cycles; no word accepted while w_valid=0.
- Pulse start again at t=10 during an active run.
  → ignored; result still matches the "abc" digest; busy never drops early.
- Assert rst at t=40.
  → next cycle: w_ready=0, busy=0, done=0, hash_out=0. A subsequent clean "abc" run produces the correct digest.
- Two back-to-back blocks, with the second start in the cycle after done and hash_in set to the first result.
  → second start accepted from IDLE; hash_out updates only on the second done.
